retire_commit_sb: RTL
=====================

// Module: retire_commit_sb
// PURPOSE
//  Parametrised N-way retire stage with an integrated committed-store buffer (SB) and halt-drain FSM.
//  Takes the ROB head window and retires the oldest in-order run of complete instructions.
//  Updates the recovery maptable and freelist, and raises branch recovery.
//  Stores are pushed into the SB at retire and drained to Dmem with a response handshake.
//  Sits between the ROB head and Dmem; wfi_halt asserts only after all committed stores are written.
// PARAMETERS
//  WAYS       `SUPERSCALAR_WAYS (3)  retire width / ROB head window size
//  SB_DEPTH   4                      committed-store entries; power of 2, >= WAYS
//  SB_IDX_W   $clog2(SB_DEPTH)       SB pointer width
// PORTS
//  clock                input  1                       rising-edge clock
//  reset                input  1                       synchronous, active-high
//  retire_rob_in        input  ROB_PACKET[WAYS]        ROB head window, [0] oldest
//  arch_maptable        input  [N_ARCH_REG][PHYS_BITS] committed arch map
//  Dmem2proc_response   input  4                       nonzero = head store accepted this cycle
//  retire_count         output $clog2(WAYS+1)          number retired this cycle (ROB pop count)
//  retire_out           output RETIRE_PACKET[WAYS]     per-way retire info, zero when not retiring
//  retire_freelist_out  output RETIRE_FREELIST_PACKET[WAYS]  told_idx + valid
//  recovery_maptable    output MAPTABLE_PACKET         arch map updated with this cycle's retirements
//  br_recover_enable    output 1                       precise-state recovery request
//  target_pc            output XLEN                    recovery PC
//  proc2Dmem_command    output 2                       BUS_STORE while SB non-empty, else BUS_NONE
//  proc2Dmem_addr       output XLEN                    SB head address
//  proc2Dmem_data       output XLEN                    SB head data
//  sb_empty             output 1                       SB holds no entries
//  wfi_halt             output 1                       processor halted, SB drained
// BEHAVIOUR
//  Retire enable chain (combinational):
//   en[0] = complete[0] & state==RUN & slot_ok[0].
//   en[i] = en[i-1] & complete[i] & ~precise_state_enable[i-1] & ~halt[i-1] & slot_ok[i].
//   slot_ok[i]: if wr_mem[i], (stores in ways 0..i) <= SB_DEPTH - sb_count.
//   sb_count is the registered count. A same-cycle pop does not free a slot (conservative).
//  retire_out[i] / freelist[i] are populated only when en[i]; otherwise all-zero.
//   result = NPC if precise_state_enable, else dest_value.
//  recovery_maptable starts from arch_maptable with done=1.
//   Enabled ways overwrite map[ar_idx] = t_idx in ascending order; the youngest wins.
//   Ways with ar_idx==0 do not write.
//  br_recover_enable/target_pc come from the enabled way with precise_state_enable.
//   At most one such way exists, since the chain stops after it.
//  Loads are serviced upstream. This block issues stores only.
//  SB: FIFO of {addr=dest_value, data=opb}; up to WAYS pushes/cycle in way order; 1 pop/cycle.
//   The head is presented every cycle while non-empty.
//   Pop occurs on Dmem2proc_response != 0; the command is held stable until accepted.
//   Pointers wrap modulo SB_DEPTH.
//   Simultaneous push+pop: count += pushes - pop.
//  Branch recovery does not flush the SB (its entries are committed).
//  FSM states:
//   RUN: normal operation. An enabled halt moves the FSM to DRAIN, or to HALTED if the SB is empty after this cycle.
//   DRAIN: en all 0; the SB keeps draining. Moves to HALTED when the count reaches 0.
//   HALTED: wfi_halt=1; en all 0. Held until reset.
//  Reset (mid-operation included): SB ptrs/count=0, entries discarded, state=RUN.
//   All outputs read 0 / BUS_NONE, and sb_empty=1.
//  Latency: retire is same-cycle. A store reaches Dmem on the cycle after it retires, at the earliest.
// CONFIGURATION
//  RETIRE_PERF_CNT_EN defined:
//   Adds output perf_retired[63:0] (+= retire_count each cycle).
//   Adds output perf_sb_stall[63:0] (+1 each cycle a complete head way is blocked only by slot_ok).
//   Both counters are cleared on reset.
//  RETIRE_PERF_CNT_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package: SB_ENTRY typedef {addr, data}, RETIRE_STATE enum {RUN, DRAIN, HALTED}.
//   RETIRE_PACKET, RETIRE_FREELIST_PACKET, and MAPTABLE_PACKET stay as existing.
//  Sub-module store_buffer holds the multi-push / single-pop FIFO with registered count.
//  The enable chain, maptable update and FSM live in the top.
// TESTING
//  Ways 0,1,2 complete, no mem/branch -> retire_count=3; map[ar_idx] = t_idx; 3 valid freelist entries.
//  Way0 incomplete, ways 1,2 complete -> retire_count=0; all outputs zero.
//  Way1 precise_state_enable, target_pc=0x100 -> count=2; br_recover_enable=1; target_pc=0x100; way2 not retired.
//  SB holds 3 of 4; ways 0,1 are stores -> only way0 retires; next cycle proc2Dmem_command=BUS_STORE at head addr.
//  Response=0 for 5 cycles -> head addr/data held stable; response=1 -> pop; count decrements.
//  Halt retires with 2 stores queued -> wfi_halt=0 until both are accepted, then wfi_halt=1 and stays set.
//  Reset asserted in DRAIN -> next cycle sb_empty=1, wfi_halt=0, state RUN.

Source files
------------

// File: rtl/retire_commit_sb_pkg.sv
// Shared types for the retire stage: ROB/retire/freelist/maptable packets, store-buffer entry, FSM states.
package retire_commit_sb_pkg;

    localparam int XLEN             = 32;
    localparam int SUPERSCALAR_WAYS = 3;
    localparam int N_ARCH_REG       = 32;
    localparam int PHYS_BITS        = 6;
    localparam int ARCH_BITS        = $clog2(N_ARCH_REG);

    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;

    typedef struct packed {
        logic                 complete;
        logic                 precise_state_enable;
        logic                 halt;
        logic                 wr_mem;
        logic [ARCH_BITS-1:0] ar_idx;
        logic [PHYS_BITS-1:0] t_idx;
        logic [PHYS_BITS-1:0] told_idx;
        logic [XLEN-1:0]      dest_value;
        logic [XLEN-1:0]      opb;
        logic [XLEN-1:0]      NPC;
        logic [XLEN-1:0]      target_pc;
    } ROB_PACKET;

    typedef struct packed {
        logic                 valid;
        logic                 halt;
        logic [ARCH_BITS-1:0] ar_idx;
        logic [PHYS_BITS-1:0] t_idx;
        logic [XLEN-1:0]      result;
        logic [XLEN-1:0]      NPC;
    } RETIRE_PACKET;

    typedef struct packed {
        logic [PHYS_BITS-1:0] told_idx;
        logic                 valid;
    } RETIRE_FREELIST_PACKET;

    typedef struct packed {
        logic [N_ARCH_REG-1:0][PHYS_BITS-1:0] map;
        logic                                 done;
    } MAPTABLE_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } SB_ENTRY;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } RETIRE_STATE;

endpackage

// File: rtl/retire_commit_sb_store_buffer.sv
// Committed-store FIFO: up to WAYS pushes per cycle in way order, one pop per cycle.
// Latency: an entry pushed this cycle is visible at the head from the next cycle.
// Backpressure: none internally; the producer must never push beyond the free slots.
module store_buffer
    import retire_commit_sb_pkg::*;
#(
    parameter int WAYS  = 3,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WAYS-1:0]  push_vld,
    input  SB_ENTRY          push_dat [WAYS],
    input  logic             pop,
    output SB_ENTRY          head_dat,
    output logic [IDX_W:0]   count,
    output logic [IDX_W:0]   count_nxt,
    output logic             empty
);

    SB_ENTRY          mem_q [DEPTH];
    SB_ENTRY          mem_d [DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        tail_d  = tail_q;
        head_d  = head_q;
        count_d = count_q;
        // Pushes are compacted: each valid way takes the next free slot after the previous one.
        for (int i = 0; i < WAYS; i++) begin
            if (push_vld[i]) begin
                mem_d[tail_d] = push_dat[i];
                tail_d        = tail_d + IDX_W'(1);
                count_d       = count_d + (IDX_W+1)'(1);
            end
        end
        if (pop) begin
            head_d  = head_q + IDX_W'(1);
            count_d = count_d - (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_dat  = mem_q[head_q];
    assign count     = count_q;
    assign count_nxt = count_d;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/retire_commit_sb.sv
// N-way in-order retire with committed-store buffer and halt drain; optional perf counters via RETIRE_PERF_CNT_EN.
// Latency: retire is combinational; a retired store reaches Dmem one cycle later at the earliest.
// Backpressure: stores retire only into free SB slots; the Dmem command is held until response != 0.
module retire_commit_sb
    import retire_commit_sb_pkg::*;
#(
    parameter int WAYS     = SUPERSCALAR_WAYS,
    parameter int SB_DEPTH = 4,
    parameter int SB_IDX_W = $clog2(SB_DEPTH)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  ROB_PACKET                            retire_rob_in [WAYS],
    input  logic [N_ARCH_REG-1:0][PHYS_BITS-1:0] arch_maptable,
    input  logic [3:0]                           Dmem2proc_response,
    output logic [$clog2(WAYS+1)-1:0]            retire_count,
    output RETIRE_PACKET                         retire_out [WAYS],
    output RETIRE_FREELIST_PACKET                retire_freelist_out [WAYS],
    output MAPTABLE_PACKET                       recovery_maptable,
    output logic                                 br_recover_enable,
    output logic [XLEN-1:0]                      target_pc,
    output logic [1:0]                           proc2Dmem_command,
    output logic [XLEN-1:0]                      proc2Dmem_addr,
    output logic [XLEN-1:0]                      proc2Dmem_data,
    output logic                                 sb_empty,
    output logic                                 wfi_halt
`ifdef RETIRE_PERF_CNT_EN
    ,
    output logic [63:0]                          perf_retired,
    output logic [63:0]                          perf_sb_stall
`endif
);

    localparam int RC_W  = $clog2(WAYS+1);
    localparam int CNT_W = SB_IDX_W + 1;

    RETIRE_STATE      state_q, state_d;
    logic [WAYS-1:0]  pre_en, slot_ok, en, push_vld;
    SB_ENTRY          push_dat [WAYS];
    SB_ENTRY          sb_head;
    logic [CNT_W-1:0] sb_count, sb_count_nxt;
    logic             sb_is_empty, sb_pop, halt_retired;

    // Slot check uses the registered count only; a same-cycle pop is not credited.
    always_comb begin
        int   stores;
        int   free_slots;
        logic chain;
        pre_en     = '0;
        slot_ok    = '0;
        en         = '0;
        stores     = 0;
        free_slots = SB_DEPTH - int'(sb_count);
        chain      = (state_q == RUN) && !reset;
        for (int i = 0; i < WAYS; i++) begin
            if (retire_rob_in[i].wr_mem) stores++;
            slot_ok[i] = !retire_rob_in[i].wr_mem || (stores <= free_slots);
            pre_en[i]  = chain && retire_rob_in[i].complete;
            en[i]      = pre_en[i] && slot_ok[i];
            chain      = en[i] && !retire_rob_in[i].precise_state_enable && !retire_rob_in[i].halt;
        end
    end

    always_comb begin
        retire_count      = '0;
        br_recover_enable = 1'b0;
        target_pc         = '0;
        halt_retired      = 1'b0;
        push_vld          = '0;
        recovery_maptable = '0;
        if (!reset) begin
            recovery_maptable.map  = arch_maptable;
            recovery_maptable.done = 1'b1;
        end
        for (int i = 0; i < WAYS; i++) begin
            retire_out[i]          = '0;
            retire_freelist_out[i] = '0;
            push_dat[i].addr       = retire_rob_in[i].dest_value;
            push_dat[i].data       = retire_rob_in[i].opb;
            if (en[i]) begin
                retire_out[i].valid           = 1'b1;
                retire_out[i].halt            = retire_rob_in[i].halt;
                retire_out[i].ar_idx          = retire_rob_in[i].ar_idx;
                retire_out[i].t_idx           = retire_rob_in[i].t_idx;
                retire_out[i].result          = retire_rob_in[i].precise_state_enable ?
                                                retire_rob_in[i].NPC : retire_rob_in[i].dest_value;
                retire_out[i].NPC             = retire_rob_in[i].NPC;
                retire_freelist_out[i].told_idx = retire_rob_in[i].told_idx;
                retire_freelist_out[i].valid  = 1'b1;
                retire_count                  = retire_count + RC_W'(1);
                push_vld[i]                   = retire_rob_in[i].wr_mem;
                if (retire_rob_in[i].halt) halt_retired = 1'b1;
                if (retire_rob_in[i].ar_idx != '0)
                    recovery_maptable.map[retire_rob_in[i].ar_idx] = retire_rob_in[i].t_idx;
                if (retire_rob_in[i].precise_state_enable) begin
                    br_recover_enable = 1'b1;
                    target_pc         = retire_rob_in[i].target_pc;
                end
            end
        end
    end

    store_buffer #(
        .WAYS  (WAYS),
        .DEPTH (SB_DEPTH),
        .IDX_W (SB_IDX_W)
    ) u_sb (
        .clock     (clock),
        .reset     (reset),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .pop       (sb_pop),
        .head_dat  (sb_head),
        .count     (sb_count),
        .count_nxt (sb_count_nxt),
        .empty     (sb_is_empty)
    );

    assign sb_pop            = (Dmem2proc_response != 4'h0) && !sb_is_empty;
    assign sb_empty          = sb_is_empty || reset;
    assign proc2Dmem_command = sb_empty ? BUS_NONE : BUS_STORE;
    assign proc2Dmem_addr    = sb_empty ? '0 : sb_head.addr;
    assign proc2Dmem_data    = sb_empty ? '0 : sb_head.data;
    assign wfi_halt          = (state_q == HALTED) && !reset;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (halt_retired) state_d = (sb_count_nxt == '0) ? HALTED : DRAIN;
            DRAIN:   if (sb_count_nxt == '0) state_d = HALTED;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

`ifdef RETIRE_PERF_CNT_EN
    logic [63:0] perf_retired_q, perf_retired_d;
    logic [63:0] perf_sb_stall_q, perf_sb_stall_d;

    always_comb begin
        perf_retired_d  = perf_retired_q + 64'(retire_count);
        perf_sb_stall_d = perf_sb_stall_q + 64'(|(pre_en & ~slot_ok));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_retired_q  <= '0;
            perf_sb_stall_q <= '0;
        end else begin
            perf_retired_q  <= perf_retired_d;
            perf_sb_stall_q <= perf_sb_stall_d;
        end
    end

    assign perf_retired  = perf_retired_q;
    assign perf_sb_stall = perf_sb_stall_q;
`endif

endmodule
